// File: rtl/oam_dma_ctrl_pkg.sv
// Shared definitions for the OAM DMA controller: PPU mode and DMA state
// encodings, fixed register/region addresses, and the echo-RAM source mapping.
package oam_dma_ctrl_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } PPU_STATES_t;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_XFER  = 2'd2
  } dma_state_t;

  localparam logic [15:0] OAM_BASE_ADDR = 16'hFE00;
  localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;

  // E0-FF source pages mirror C0-DF (echo RAM)
  function automatic logic [7:0] src_hi_eff(input logic [7:0] hi);
    return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: an FF46 write copies DMA_LEN bytes from {src_hi,00}
// into OAM, one byte every BYTE_CYCLES clocks after a START_DELAY lead-in.
// Ports:
//   clk, rst            dot clock, async active-high reset
//   ADDR/WR/RD          CPU bus address and strobes
//   MMIO_DATA_out       CPU write data; MMIO_DATA_in FF46 readback (comb)
//   PPU_MODE            current PPU mode, drives the CPU block outputs
//   DMA_RD/DMA_ADDR     source read strobe/address; DMA_DATA_in one cycle later
//   OAM_WR/_ADDR/_DATA  OAM write strobe, byte index and data
//   DMA_ACTIVE          transfer pending or running
//   CPU_OAM_BLOCK       CPU denied FE00-FE9F
//   CPU_VRAM_BLOCK      CPU denied 8000-9FFF
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter int unsigned DMA_LEN     = 160,
  parameter int unsigned BYTE_CYCLES = 4,
  parameter int unsigned START_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ADDR,
  input  logic        WR,
  input  logic        RD,
  input  logic [7:0]  MMIO_DATA_out,
  output logic [7:0]  MMIO_DATA_in,
  input  logic [1:0]  PPU_MODE,
  output logic        DMA_RD,
  output logic [15:0] DMA_ADDR,
  input  logic [7:0]  DMA_DATA_in,
  output logic        OAM_WR,
  output logic [7:0]  OAM_WR_ADDR,
  output logic [7:0]  OAM_WR_DATA,
  output logic        DMA_ACTIVE,
  output logic        CPU_OAM_BLOCK,
  output logic        CPU_VRAM_BLOCK
);

  localparam int unsigned PW = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
  localparam int unsigned DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(BYTE_CYCLES - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'(START_DELAY - 1);
  localparam logic [7:0]    K_LAST   = 8'(DMA_LEN - 1);

  dma_state_t    state, state_n;
  logic [7:0]    src_hi, src_hi_n;
  logic [DW-1:0] dly, dly_n;
  logic [7:0]    k, k_n;
  logic [PW-1:0] phase, phase_n;
  logic          dma_rd_n, oam_wr_n, reg_wr;

  // Reads are side-effect free, so the read strobe carries no information here
  logic unused_rd;
  assign unused_rd = RD;

  assign reg_wr = WR && (ADDR == DMA_REG_ADDR);

  // State, counters and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= DMA_IDLE;
      src_hi      <= 8'h00;
      dly         <= '0;
      k           <= 8'h00;
      phase       <= '0;
      DMA_RD      <= 1'b0;
      DMA_ADDR    <= 16'h0000;
      OAM_WR      <= 1'b0;
      OAM_WR_ADDR <= 8'h00;
      DMA_ACTIVE  <= 1'b0;
    end else begin
      state      <= state_n;
      src_hi     <= src_hi_n;
      dly        <= dly_n;
      k          <= k_n;
      phase      <= phase_n;
      DMA_RD     <= dma_rd_n;
      OAM_WR     <= oam_wr_n;
      DMA_ACTIVE <= (state_n != DMA_IDLE);
      if (dma_rd_n) DMA_ADDR    <= {src_hi_eff(src_hi_n), k_n};
      if (oam_wr_n) OAM_WR_ADDR <= k_n;
    end
  end

  // Next state; strobes are decoded from the next state so they are registered
  always_comb begin
    state_n  = state;
    src_hi_n = src_hi;
    dly_n    = dly;
    k_n      = k;
    phase_n  = phase;
    case (state)
      DMA_IDLE: ;
      DMA_START: begin
        if (dly == DLY_LAST) begin
          state_n = DMA_XFER;
          k_n     = 8'h00;
          phase_n = '0;
        end else begin
          dly_n = dly + DW'(1);
        end
      end
      DMA_XFER: begin
        if (phase == PH_LAST) begin
          phase_n = '0;
          if (k == K_LAST) begin
            state_n = DMA_IDLE;
            k_n     = 8'h00;
          end else begin
            k_n = k + 8'd1;
          end
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      default: state_n = DMA_IDLE;
    endcase
    // A register write restarts from any state
    if (reg_wr) begin
      state_n  = DMA_START;
      src_hi_n = MMIO_DATA_out;
      dly_n    = '0;
      k_n      = 8'h00;
      phase_n  = '0;
    end
    dma_rd_n = (state_n == DMA_XFER) && (phase_n == '0);
    oam_wr_n = (state_n == DMA_XFER) && (phase_n == PW'(1));
  end

  // Source data arrives during the write phase, so it passes straight through
  assign OAM_WR_DATA    = OAM_WR ? DMA_DATA_in : 8'h00;
  assign MMIO_DATA_in   = (ADDR == DMA_REG_ADDR) ? src_hi : 8'hFF;
  assign CPU_OAM_BLOCK  = DMA_ACTIVE || (PPU_MODE == SCAN) || (PPU_MODE == DRAW);
  assign CPU_VRAM_BLOCK = (PPU_MODE == DRAW);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  logic        clk, rst;
  logic [15:0] ADDR;
  logic        WR, RD;
  logic [7:0]  MMIO_DATA_out, MMIO_DATA_in;
  logic [1:0]  PPU_MODE;
  logic        DMA_RD;
  logic [15:0] DMA_ADDR;
  logic [7:0]  DMA_DATA_in;
  logic        OAM_WR;
  logic [7:0]  OAM_WR_ADDR, OAM_WR_DATA;
  logic        DMA_ACTIVE, CPU_OAM_BLOCK, CPU_VRAM_BLOCK;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0, rd_cnt = 0, data_err = 0, both_err = 0;
  logic [7:0] mem_q = 8'h00;

  oam_dma_ctrl dut (
    .clk(clk), .rst(rst), .ADDR(ADDR), .WR(WR), .RD(RD),
    .MMIO_DATA_out(MMIO_DATA_out), .MMIO_DATA_in(MMIO_DATA_in),
    .PPU_MODE(PPU_MODE), .DMA_RD(DMA_RD), .DMA_ADDR(DMA_ADDR),
    .DMA_DATA_in(DMA_DATA_in), .OAM_WR(OAM_WR), .OAM_WR_ADDR(OAM_WR_ADDR),
    .OAM_WR_DATA(OAM_WR_DATA), .DMA_ACTIVE(DMA_ACTIVE),
    .CPU_OAM_BLOCK(CPU_OAM_BLOCK), .CPU_VRAM_BLOCK(CPU_VRAM_BLOCK)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory: data = low address byte ^ 5A, one cycle after the read
  always @(posedge clk) if (DMA_RD) mem_q <= DMA_ADDR[7:0] ^ 8'h5A;
  assign DMA_DATA_in = mem_q;

  // Strobe monitor
  always @(posedge clk) begin
    if (OAM_WR) begin
      wr_cnt = wr_cnt + 1;
      if (OAM_WR_DATA !== (OAM_WR_ADDR ^ 8'h5A)) data_err = data_err + 1;
    end
    if (DMA_RD) rd_cnt = rd_cnt + 1;
    if (DMA_RD && OAM_WR) both_err = both_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic [7:0] d);
    ADDR = 16'hFF46;
    MMIO_DATA_out = d;
    WR = 1'b1;
    tick(1);
    WR = 1'b0;
    ADDR = 16'h0000;
  endtask

  int w0, w1, r0, n;
  logic [1:0] m;
  logic [3:0] oam_blk_tab, vram_blk_tab;

  initial begin
    rst = 1'b1; ADDR = 16'h0000; WR = 1'b0; RD = 1'b0;
    MMIO_DATA_out = 8'h00; PPU_MODE = 2'd3;
    tick(3);
    // Reset state
    chk("rst_active", 32'(DMA_ACTIVE), 32'h0);
    chk("rst_dma_rd", 32'(DMA_RD), 32'h0);
    chk("rst_oam_wr", 32'(OAM_WR), 32'h0);
    chk("rst_dma_addr", 32'(DMA_ADDR), 32'h0000);
    chk("rst_oam_idx", 32'(OAM_WR_ADDR), 32'h00);
    chk("rst_oam_blk_mode3", 32'(CPU_OAM_BLOCK), 32'h1);
    chk("rst_vram_blk_mode3", 32'(CPU_VRAM_BLOCK), 32'h1);
    ADDR = 16'hFF46; #1;
    chk("rst_readback", 32'(MMIO_DATA_in), 32'h00);
    ADDR = 16'h0000; PPU_MODE = 2'd0;
    rst = 1'b0;
    tick(2);

    // Basic transfer from C1
    w0 = wr_cnt;
    cpu_write(8'hC1);                      // now cycle 1
    chk("start_active", 32'(DMA_ACTIVE), 32'h1);
    chk("start_no_rd", 32'(DMA_RD), 32'h0);
    ADDR = 16'hFF46; #1;
    chk("readback_c1", 32'(MMIO_DATA_in), 32'hC1);
    ADDR = 16'h1234; #1;
    chk("readback_other", 32'(MMIO_DATA_in), 32'hFF);
    ADDR = 16'h0000;
    tick(4);                               // cycle 5
    chk("first_rd", 32'(DMA_RD), 32'h1);
    chk("first_addr", 32'(DMA_ADDR), 32'hC100);
    chk("first_rd_no_wr", 32'(OAM_WR), 32'h0);
    tick(1);                               // cycle 6
    chk("first_wr", 32'(OAM_WR), 32'h1);
    chk("first_wr_idx", 32'(OAM_WR_ADDR), 32'h00);
    chk("first_wr_data", 32'(OAM_WR_DATA), 32'h5A);
    chk("first_wr_no_rd", 32'(DMA_RD), 32'h0);
    tick(635);                             // cycle 641
    chk("last_rd", 32'(DMA_RD), 32'h1);
    chk("last_addr", 32'(DMA_ADDR), 32'hC19F);
    tick(1);                               // cycle 642
    chk("last_wr", 32'(OAM_WR), 32'h1);
    chk("last_wr_idx", 32'(OAM_WR_ADDR), 32'h9F);
    chk("last_wr_data", 32'(OAM_WR_DATA), 32'hC5);
    tick(2);                               // cycle 644
    chk("active_644", 32'(DMA_ACTIVE), 32'h1);
    tick(1);                               // cycle 645
    chk("idle_645", 32'(DMA_ACTIVE), 32'h0);
    chk("wr_count_160", 32'(wr_cnt - w0), 32'd160);

    // Restart at byte 50 with source 80
    tick(3);
    w0 = wr_cnt;
    cpu_write(8'hC1);
    tick(204);                             // cycle 205: byte 50 read
    chk("b50_rd", 32'(DMA_RD), 32'h1);
    chk("b50_addr", 32'(DMA_ADDR), 32'hC132);
    w1 = wr_cnt;
    chk("b50_prior_writes", 32'(w1 - w0), 32'd50);
    cpu_write(8'h80);                      // new cycle 1
    chk("restart_no_wr", 32'(OAM_WR), 32'h0);
    chk("restart_no_rd", 32'(DMA_RD), 32'h0);
    chk("restart_active", 32'(DMA_ACTIVE), 32'h1);
    tick(4);
    chk("restart_rd", 32'(DMA_RD), 32'h1);
    chk("restart_addr", 32'(DMA_ADDR), 32'h8000);
    tick(1);
    chk("restart_wr", 32'(OAM_WR), 32'h1);
    chk("restart_wr_idx", 32'(OAM_WR_ADDR), 32'h00);
    n = 0;
    while (DMA_ACTIVE && n < 1000) begin
      tick(1);
      n++;
    end
    chk("restart_done_timeout", 32'(DMA_ACTIVE), 32'h0);
    chk("restart_len", 32'(n), 32'd639);
    chk("restart_wr_count", 32'(wr_cnt - w1), 32'd160);
    chk("data_errors", 32'(data_err), 32'd0);
    chk("rd_wr_overlap", 32'(both_err), 32'd0);

    // Echo source FE, then reset at byte 100
    tick(2);
    cpu_write(8'hFE);
    tick(4);
    chk("echo_addr", 32'(DMA_ADDR), 32'hDE00);
    tick(400);                             // cycle 405: byte 100 read
    chk("b100_addr", 32'(DMA_ADDR), 32'hDE64);
    rst = 1'b1;
    ADDR = 16'hFF46;
    #1;
    chk("abort_rd", 32'(DMA_RD), 32'h0);
    chk("abort_wr", 32'(OAM_WR), 32'h0);
    chk("abort_active", 32'(DMA_ACTIVE), 32'h0);
    chk("abort_readback", 32'(MMIO_DATA_in), 32'h00);
    w0 = wr_cnt; r0 = rd_cnt;
    tick(3);
    rst = 1'b0;
    tick(20);
    chk("post_rst_active", 32'(DMA_ACTIVE), 32'h0);
    chk("post_rst_wr", 32'(wr_cnt - w0), 32'd0);
    chk("post_rst_rd", 32'(rd_cnt - r0), 32'd0);
    ADDR = 16'h0000;

    // PPU mode sweep, idle then active
    oam_blk_tab  = 4'b1100;
    vram_blk_tab = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      m = 2'(i);
      PPU_MODE = m; #1;
      chk($sformatf("idle_oam_blk_m%0d", i), 32'(CPU_OAM_BLOCK), 32'(oam_blk_tab[m]));
      chk($sformatf("idle_vram_blk_m%0d", i), 32'(CPU_VRAM_BLOCK), 32'(vram_blk_tab[m]));
    end
    PPU_MODE = 2'd0;
    cpu_write(8'hC1);
    for (int i = 0; i < 4; i++) begin
      m = 2'(i);
      PPU_MODE = m; #1;
      chk($sformatf("act_oam_blk_m%0d", i), 32'(CPU_OAM_BLOCK), 32'h1);
      chk($sformatf("act_vram_blk_m%0d", i), 32'(CPU_VRAM_BLOCK), 32'(vram_blk_tab[m]));
    end
    ADDR = 16'hFF46; #1;
    chk("active_readback", 32'(MMIO_DATA_in), 32'hC1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
